// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow input in clk cycles,
// and flags the input as stalled when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned TIMEOUT     = 200_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             period_valid,
   output logic             stalled
);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      STALLED
   } state_t;

   localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   logic                   r_s_d;
   logic                   r_rise;
   logic                   r_fall;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_hcnt;
   logic [CNT_W-1:0]       r_hi_lat;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Edges are registered; r_s_d is the input level aligned with r_rise/r_fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_s_d  <= w_s;
         r_rise <= w_s & ~r_s_d;
         r_fall <= ~w_s & r_s_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_hcnt       <= '0;
         r_hi_lat     <= '0;
         period_out   <= '0;
         high_out     <= '0;
         period_valid <= 1'b0;
         stalled      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_rise) begin
                  r_state <= MEASURE;
                  r_cnt   <= ONE;
                  r_hcnt  <= ONE;
               end
            end
            MEASURE: begin
               if (r_rise) begin
                  period_out   <= r_cnt;
                  high_out     <= r_hi_lat;
                  period_valid <= 1'b1;
                  r_cnt        <= ONE;
                  r_hcnt       <= ONE;
               end else begin
                  if (r_fall) begin
                     r_hi_lat <= r_hcnt;
                  end
                  if (r_cnt == TO) begin
                     r_state <= STALLED;
                     stalled <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + ONE;
                     if (r_s_d) begin
                        r_hcnt <= r_hcnt + ONE;
                     end
                  end
               end
            end
            STALLED: begin
               // A rise after a stall only restarts the measurement, no valid pulse.
               if (r_rise) begin
                  r_state <= MEASURE;
                  stalled <= 1'b0;
                  r_cnt   <= ONE;
                  r_hcnt  <= ONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: table-driven segments, hand-written stall/reset
// sequences and random waveforms, all checked each cycle against an index-based model.
module tb_clk_period_meter;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned SS      = 2;
   localparam int          LAT     = SS + 1;
   localparam int          MAXK    = 16384;

   logic             clk    = 1'b0;
   logic             reset  = 1'b1;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             period_valid;
   logic             stalled;

   always #5 clk = ~clk;

   clk_period_meter #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .SYNC_STAGES(SS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sig_in      (sig_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .period_valid(period_valid),
      .stalled     (stalled)
   );

   typedef struct {
      logic             valid;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
      logic             stl;
   } exp_t;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_period;
      int exp_high;
   } vec_t;

   exp_t             hist[MAXK];
   vec_t             vec[6];
   int               k;
   int               last_rise;
   logic             m_stl;
   logic             prev;
   logic [CNT_W-1:0] hi_lat;
   logic [CNT_W-1:0] m_period;
   logic [CNT_W-1:0] m_high;
   int               errors = 0;
   int               checks = 0;

   // Model works on sample indices: outputs after sample k appear LAT cycles later.
   task automatic model_clear();
      k         = 0;
      last_rise = -1;
      m_stl     = 1'b0;
      prev      = 1'b0;
      hi_lat    = '0;
      m_period  = '0;
      m_high    = '0;
   endtask

   task automatic model_sample(input logic x);
      logic rise, fall, v;
      int   age;
      rise = x & ~prev;
      fall = ~x & prev;
      prev = x;
      v    = 1'b0;
      age  = k - last_rise;
      if (rise) begin
         if (last_rise >= 0 && !m_stl) begin
            m_period = CNT_W'(age);
            m_high   = hi_lat;
            v        = 1'b1;
         end
         m_stl     = 1'b0;
         last_rise = k;
      end else if (last_rise >= 0 && !m_stl) begin
         if (fall) hi_lat = CNT_W'(age);
         if (age == int'(TIMEOUT)) m_stl = 1'b1;
      end
      if (k < MAXK) hist[k] = '{v, m_period, m_high, m_stl};
      k++;
   endtask

   task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   task automatic tick(input logic v);
      exp_t e;
      int   idx;
      sig_in = v;
      @(posedge clk);
      if (reset) model_sample(v);
      #1;
      e   = '{1'b0, '0, '0, 1'b0};
      idx = k - 1 - LAT;
      if (reset && idx >= 0 && idx < MAXK) e = hist[idx];
      check("period_valid", CNT_W'(period_valid), CNT_W'(e.valid));
      check("period_out", period_out, e.period);
      check("high_out", high_out, e.high);
      check("stalled", CNT_W'(stalled), CNT_W'(e.stl));
   endtask

   task automatic seg(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi; i++) tick(1'b1);
         for (int i = 0; i < lo; i++) tick(1'b0);
      end
   endtask

   initial begin
      vec[0] = '{5, 5, 6, 10, 5};
      vec[1] = '{8, 8, 4, 16, 8};
      vec[2] = '{32, 32, 3, 64, 32};
      vec[3] = '{3, 1, 4, 4, 3};
      vec[4] = '{1, 63, 3, 64, 1};
      vec[5] = '{2, 5, 3, 7, 2};

      model_clear();
      #1 reset = 1'b0;

      // Toggling input while held in reset must leave everything at zero.
      for (int i = 0; i < 20; i++) tick(logic'((i / 3) % 2));
      reset = 1'b1;
      model_clear();

      for (int i = 0; i < 6; i++) begin
         seg(vec[i].hi, vec[i].lo, vec[i].reps);
         check("tbl_period", period_out, CNT_W'(vec[i].exp_period));
         check("tbl_high", high_out, CNT_W'(vec[i].exp_high));
         check("tbl_stalled", CNT_W'(stalled), '0);
      end

      for (int i = 0; i < 100; i++) tick(1'b0);
      check("stall_flag", CNT_W'(stalled), CNT_W'(1));
      check("stall_hold_period", period_out, CNT_W'(7));
      check("stall_hold_high", high_out, CNT_W'(2));
      seg(5, 5, 4);
      check("restart_stalled", CNT_W'(stalled), '0);
      check("restart_period", period_out, CNT_W'(10));
      check("restart_high", high_out, CNT_W'(5));

      seg(10, 10, 3);
      for (int i = 0; i < 7; i++) tick(1'b1);
      reset = 1'b0;
      #1;
      check("async_rst_period", period_out, '0);
      check("async_rst_high", high_out, '0);
      check("async_rst_valid", CNT_W'(period_valid), '0);
      model_clear();
      tick(1'b1);
      tick(1'b1);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0);
      seg(10, 10, 2);
      check("post_rst_period", period_out, CNT_W'(20));
      check("post_rst_high", high_out, CNT_W'(10));

      for (int s = 0; s < 30; s++) begin
         int hi, lo, reps;
         hi   = int'($urandom_range(1, 40));
         lo   = int'($urandom_range(1, 40));
         reps = int'($urandom_range(1, 3));
         seg(hi, lo, reps);
         if ($urandom_range(0, 7) == 0) begin
            int gap;
            gap = int'($urandom_range(60, 90));
            for (int i = 0; i < gap; i++) tick(1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
